// File: rtl/sim_imem_pipe.sv
// Pipelined, back-pressured instruction memory for simulation: requests are read
// from the memory image, delayed LATENCY cycles, then returned in order from a FIFO.
module sim_imem_pipe #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ioIMem_valid,
    output logic                  ioIMem_ready,
    input  logic [ADDR_WIDTH-1:0] ioIMem_pc,
    input  logic                  ioIMem_flush,
    output logic                  ioIMem_respValid,
    input  logic                  ioIMem_respReady,
    output logic [INST_WIDTH-1:0] ioIMem_inst,
    output logic                  ioIMem_err,
    output logic                  ioIMem_busy
);

    localparam int WORDS = INST_WIDTH / 32;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Memory image seen by the core: a fixed function of the word address.
    function automatic logic [31:0] dpic_imem_read(input logic [ADDR_WIDTH-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      fifoCount;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic                  accept;
    logic                  pop;
    logic                  enq;
    logic                  fetchErr;
    logic [INST_WIDTH-1:0] fetchData;

    logic [LATENCY-1:0]    dlyVld_p;
    logic [LATENCY-1:0]    dlyErr_p;
    logic [INST_WIDTH-1:0] dlyInst_p [LATENCY];

    logic [INST_WIDTH-1:0] fifoInst [DEPTH];
    logic [DEPTH-1:0]      fifoErr;

    assign ioIMem_ready     = reset && !ioIMem_flush && (count < CNT_W'(DEPTH));
    assign accept           = ioIMem_valid && ioIMem_ready;
    assign ioIMem_respValid = (fifoCount != '0);
    assign pop              = ioIMem_respValid && ioIMem_respReady && !ioIMem_flush;
    assign enq              = dlyVld_p[LATENCY-1];
    assign ioIMem_busy      = (count != '0);
    assign ioIMem_inst      = ioIMem_respValid ? fifoInst[rdPtr] : '0;
    assign ioIMem_err       = ioIMem_respValid && fifoErr[rdPtr];

    // Fetch: memory is only read for accepted, word-aligned requests.
    always_comb begin
        fetchErr  = (ioIMem_pc[1:0] != 2'b00);
        fetchData = '0;
        if (accept && !fetchErr) begin
            for (int k = 0; k < WORDS; k++) begin
                fetchData[32*k +: 32] = dpic_imem_read(ioIMem_pc + ADDR_WIDTH'(4 * k));
            end
        end
    end

    // Delay line: stage 0 loads on accept, the last stage feeds the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dlyVld_p <= '0;
        end else if (ioIMem_flush) begin
            dlyVld_p <= '0;
        end else begin
            dlyVld_p[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                dlyVld_p[k] <= dlyVld_p[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            dlyInst_p[0] <= fetchData;
            dlyErr_p[0]  <= fetchErr;
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (dlyVld_p[k-1]) begin
                dlyInst_p[k] <= dlyInst_p[k-1];
                dlyErr_p[k]  <= dlyErr_p[k-1];
            end
        end
    end

    // Response FIFO and outstanding count; count covers delay line plus FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            count     <= '0;
        end else if (ioIMem_flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            count     <= '0;
        end else begin
            if (enq) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            fifoCount <= fifoCount + CNT_W'(enq) - CNT_W'(pop);
            count     <= count + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            fifoInst[wrPtr] <= dlyInst_p[LATENCY-1];
            fifoErr[wrPtr]  <= dlyErr_p[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_sim_imem_pipe.sv
// Bench for sim_imem_pipe: directed scenarios plus random traffic, checked every
// cycle against a queue model of outstanding requests with arrival times.
module tb_sim_imem_pipe;

    localparam int IW  = 64;
    localparam int AW  = 32;
    localparam int LAT = 3;
    localparam int DEP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          valid = 1'b0;
    logic          flush = 1'b0;
    logic          respReady = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          ready;
    logic          respValid;
    logic [IW-1:0] inst;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    sim_imem_pipe #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock            (clock),
        .reset            (reset),
        .ioIMem_valid     (valid),
        .ioIMem_ready     (ready),
        .ioIMem_pc        (pc),
        .ioIMem_flush     (flush),
        .ioIMem_respValid (respValid),
        .ioIMem_respReady (respReady),
        .ioIMem_inst      (inst),
        .ioIMem_err       (err),
        .ioIMem_busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image contents as the C++ side would hold them.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    typedef struct packed {
        logic [IW-1:0] inst;
        logic          err;
        logic [31:0]   readyAt;
    } ent_t;

    ent_t        mq[$];
    int unsigned cyc = 0;

    function automatic ent_t mkEnt(input logic [AW-1:0] a, input int unsigned at);
        ent_t e;
        e.inst    = '0;
        e.err     = (a[1:0] != 2'b00);
        e.readyAt = at;
        if (!e.err) begin
            for (int k = 0; k < IW / 32; k++) e.inst[32*k +: 32] = memWord(a + 32'(4 * k));
        end
        return e;
    endfunction

    // Model: every accepted request becomes visible LAT edges later, popped in order.
    always @(posedge clock or negedge reset) begin
        bit hv;
        bit er;
        if (!reset) begin
            mq.delete();
        end else begin
            hv = (mq.size() != 0) && (mq[0].readyAt <= cyc);
            er = !flush && (mq.size() < DEP);
            cyc++;
            if (flush) begin
                mq.delete();
            end else begin
                if (hv && respReady) void'(mq.pop_front());
                if (valid && er) mq.push_back(mkEnt(pc, cyc + LAT));
            end
        end
    end

    always @(negedge clock) begin
        bit eV;
        if (started) begin
            eV = reset && (mq.size() != 0) && (mq[0].readyAt <= cyc);
            check("m_ready", ready, reset && !flush && (mq.size() < DEP));
            check("m_respValid", respValid, eV);
            check("m_busy", busy, reset && (mq.size() != 0));
            if (!reset) begin
                check("m_rst_inst", inst, '0);
                check("m_rst_err", err, 1'b0);
            end else if (eV) begin
                check("m_inst", inst, mq[0].inst);
                check("m_err", err, mq[0].err);
            end
        end
    end

    task automatic cyc1();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        flush = 1'b0;
        respReady = 1'b1;
        repeat (n) cyc1();
    endtask

    task automatic waitResp(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (respValid) break;
            cyc1();
        end
        check(name, respValid, 1'b1);
    endtask

    logic [IW-1:0] ordExp [3];
    int            rrPct;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        started = 1'b1;
        reset = 1'b1;
        check("pin_mem", 64'(memWord(32'h8000_0010)), 64'hDEBD3EEF);

        // Wide fetch and exact latency
        valid = 1'b1; pc = 32'h8000_0010; respReady = 1'b0;
        @(negedge clock);
        check("ready_after_reset", ready, 1'b1);
        cyc1();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("wide_lat_wait", respValid, 1'b0);
            cyc1();
        end
        @(negedge clock);
        check("wide_lat_valid", respValid, 1'b1);
        check("wide_inst", inst, 64'hDEB93EEF_DEBD3EEF);
        check("wide_err", err, 1'b0);
        idle(6);

        // Latency and ordering with back-to-back requests
        ordExp[0] = 64'hDEA93EEF_DEAD3EEF;
        ordExp[1] = 64'hDEA53EEF_DEA93EEF;
        ordExp[2] = 64'hDEA13EEF_DEA53EEF;
        valid = 1'b1; pc = 32'h8000_0000; respReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc1();
            if (i == 0) pc = 32'h8000_0004;
            if (i == 1) pc = 32'h8000_0008;
            if (i == 2) valid = 1'b0;
            @(negedge clock);
            if (i >= 3 && i <= 5) begin
                check("ord_valid", respValid, 1'b1);
                check("ord_inst", inst, ordExp[i-3]);
            end else begin
                check("ord_gap", respValid, 1'b0);
            end
        end
        idle(6);

        // Back-pressure: fill, stall, pop one, accept again
        respReady = 1'b0; valid = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            pc = 32'h8000_0040 + 32'(8 * i);
            @(negedge clock);
            check("bp_ready_open", ready, 1'b1);
            cyc1();
        end
        pc = 32'h8000_0080;
        @(negedge clock);
        check("bp_full", ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        repeat (3) cyc1();
        respReady = 1'b1;
        @(negedge clock);
        check("bp_head", respValid, 1'b1);
        check("bp_still_full", ready, 1'b0);
        cyc1();
        respReady = 1'b0;
        @(negedge clock);
        check("bp_reopen", ready, 1'b1);
        cyc1();
        valid = 1'b0;
        idle(12);

        // Flush with responses in both the FIFO and the delay line
        respReady = 1'b0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h8000_0200 + 32'(4 * i);
            cyc1();
        end
        valid = 1'b0;
        cyc1();
        flush = 1'b1;
        @(negedge clock);
        check("fl_ready", ready, 1'b0);
        check("fl_head", respValid, 1'b1);
        cyc1();
        flush = 1'b0;
        @(negedge clock);
        check("fl_respValid", respValid, 1'b0);
        check("fl_busy", busy, 1'b0);
        valid = 1'b1; pc = 32'h8000_0100; respReady = 1'b1;
        cyc1();
        valid = 1'b0;
        waitResp("fl_new_arrive");
        check("fl_new_inst", inst, 64'hDFA93EEF_DFAD3EEF);
        cyc1();
        @(negedge clock);
        check("fl_only_one", respValid, 1'b0);
        idle(6);

        // Misaligned fetch followed by an aligned one
        respReady = 1'b1; valid = 1'b1; pc = 32'h8000_0002;
        cyc1();
        pc = 32'h8000_0020;
        cyc1();
        valid = 1'b0;
        waitResp("mis_arrive");
        check("mis_err", err, 1'b1);
        check("mis_inst", inst, '0);
        cyc1();
        @(negedge clock);
        check("mis_next_valid", respValid, 1'b1);
        check("mis_next_err", err, 1'b0);
        check("mis_next_inst", inst, 64'hDE893EEF_DE8D3EEF);
        idle(6);

        // Asynchronous reset with outstanding requests
        respReady = 1'b0; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h8000_0300 + 32'(4 * i);
            cyc1();
        end
        valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", ready, 1'b0);
        check("rst_respValid", respValid, 1'b0);
        check("rst_inst", inst, '0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        cyc1();
        cyc1();
        reset = 1'b1;
        @(negedge clock);
        check("rel_ready", ready, 1'b1);
        check("rel_busy", busy, 1'b0);
        check("rel_respValid", respValid, 1'b0);
        idle(6);

        // Random traffic
        rrPct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: rrPct = 20;
                    1: rrPct = 50;
                    2: rrPct = 90;
                    default: rrPct = 100;
                endcase
            end
            valid = ($urandom_range(0, 99) < 65);
            pc = 32'h8000_0000 + 32'($urandom_range(0, 63) << 2);
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            respReady = ($urandom_range(0, 99) < rrPct);
            flush = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 499) != 0);
            cyc1();
        end
        reset = 1'b1;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_imem_pipe.md
# sim_imem_pipe

Simulation-only instruction memory that replaces the zero-latency, always-ready fetch model with a pipelined, back-pressured one. Requests are accepted under a valid/ready handshake, backed by the `dpic_imem_read` DPI-C function, delayed by a configurable latency, and returned in order through a bounded response queue. The block sits between the core's fetch stage and the C++ simulation memory. It lets the bench exercise fetch stalls, multi-cycle latency, flushes and wide fetch without changing the core.

## Interface
- INST_WIDTH, 32: response data width; must be a multiple of 32 (1, 2 or 4 words per fetch).
- ADDR_WIDTH, 32: fetch address width.
- LATENCY, 1: cycles from accept to response; legal range 1..8.
- DEPTH, 4: maximum outstanding requests (accepted but not yet popped); legal range 1..16.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ioIMem_valid  in  1  fetch request valid.
- ioIMem_ready  out  1  request can be accepted this cycle.
- ioIMem_pc  in  ADDR_WIDTH  fetch address.
- ioIMem_flush  in  1  discard all in-flight and queued responses.
- ioIMem_respValid  out  1  response at head of queue.
- ioIMem_respReady  in  1  consumer pops head.
- ioIMem_inst  out  INST_WIDTH  response data; word k in bits [32k+31:32k].
- ioIMem_err  out  1  head response is a misaligned fetch.
- ioIMem_busy  out  1  at least one request outstanding.

## Operation
- Accept occurs when valid && ready at a rising edge.
- ready = reset deasserted && !flush && count < DEPTH. `count` is the number of outstanding requests.
- On accept with pc[1:0] == 0:
  - Call dpic_imem_read(pc + 4k) for k = 0..INST_WIDTH/32-1 in that edge's evaluation.
  - Pack the results, plus err=0, into stage 0 of a LATENCY-deep valid/data delay line.
- On accept with pc[1:0] != 0:
  - No DPI call.
  - Enqueue inst=0 with err=1.
- The delay-line tail enters a DEPTH-entry in-order FIFO.
  - The FIFO cannot overflow, because count ≤ DEPTH bounds delay-line plus FIFO occupancy.
  - Enqueue and pop in the same cycle are legal at any occupancy.
- respValid = FIFO non-empty. inst and err reflect the FIFO head. Pop on respValid && respReady.
- count update: count + accept − pop. The counter is ceil(log2(DEPTH+1)) bits. Pointers wrap modulo DEPTH.
- busy = (count != 0).
- flush, synchronous:
  - Clears all delay-line valid bits, FIFO pointers and count at the edge.
  - No accept occurs in the flush cycle, because ready is 0.
  - A pop in the flush cycle is ignored.
  - respValid is 0 in the following cycle.
- reset asserted, at any time including mid-transfer:
  - Immediately clears all state.
  - Drives ready=0, respValid=0, inst=0, err=0, busy=0.
  - No DPI calls occur while reset is low.
- Responses are returned strictly in request order. No reordering and no merging.

## Timing
- A request accepted at edge N has respValid=1 visible after edge N+LATENCY, assuming no flush.
- Throughput:
  - One accept per cycle is sustainable with respReady held at 1 when DEPTH ≥ LATENCY+1.
  - Otherwise ready deasserts periodically.
- ready depends combinationally on count and flush only, never on valid.
- respValid, inst and err are registered (FIFO head). They do not depend combinationally on ioIMem_valid or ioIMem_pc.
- After reset release, ready=1 in the first cycle.
- Holding respReady=0:
  - The FIFO fills.
  - ready drops once count reaches DEPTH.
  - ready reasserts the cycle after the first pop.

## Test plan
- Reset behaviour:
  - Stimulus: pulse reset low mid-stream with 3 outstanding requests.
  - Required: all outputs read 0 immediately.
  - Required: ready=1 and busy=0 the first cycle after release; no stale responses.
- Latency and ordering:
  - Stimulus: LATENCY=3, DEPTH=4; back-to-back pcs 0x80000000, 0x80000004, 0x80000008 with respReady=1.
  - Required: responses at cycles N+3, N+4, N+5, in order, matching DPI memory.
- Back-pressure:
  - Stimulus: DEPTH=2, respReady=0; issue 3 requests.
  - Required: ready=0 after the 2nd accept.
  - Required: after one pop, ready=1 next cycle; the 3rd response follows in order.
- Flush:
  - Stimulus: 3 outstanding, one of them still in the delay line; assert flush 1 cycle.
  - Required: respValid=0 and busy=0 afterwards.
  - Required: a new request at pc 0x80000100 returns only that word.
- Misaligned fetch:
  - Stimulus: pc=0x80000002.
  - Required: response with err=1, inst=0, no DPI call.
  - Required: the aligned request that follows returns err=0.
- Wide fetch:
  - Stimulus: INST_WIDTH=64, pc=0x80000010.
  - Required: inst[31:0]=mem[0x80000010], inst[63:32]=mem[0x80000014].
